// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath.
//   mult_state_t : control states of the sequential multiplier
//   count_width  : width of a step counter that must reach DATA_WIDTH
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for shift_add_multiplier.
//   in_valid/in_ready   : operand transfer (a, b)
//   out_valid/out_ready : result transfer (result, overflow)
// master = producer of operands / consumer of results, slave = multiplier.
interface shift_add_multiplier_if #(
  parameter int DATA_WIDTH = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] a;
  logic signed [DATA_WIDTH-1:0] b;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] result;
  logic                         overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );

endinterface

// File: rtl/full_adder.sv
// Combinational DATA_WIDTH-bit ripple-carry adder.
//   a, b      : addends
//   carry_in  : carry into bit 0
//   sum       : a + b + carry_in, low DATA_WIDTH bits
//   carry_out : carry out of the top bit
module full_adder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out
);

  // Single running carry keeps the chain a scalar ripple, bit 0 upward.
  logic cy;

  always_comb begin
    cy  = carry_in;
    sum = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    carry_out = cy;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed multiplier: sign-magnitude right-shift shift-and-add
// over DATA_WIDTH steps, followed by one cycle of conditional negation.
// A single full_adder is shared between the accumulate and negate steps.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of shift_add_multiplier_if
//              (a, b in; result, overflow out; valid/ready on both)
module shift_add_multiplier
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = count_width(DATA_WIDTH);

  mult_state_t state_q, state_d;

  logic [W-1:0]  mcand;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [CW-1:0] count;
  logic          sign;
  logic signed [W-1:0] result_q;
  logic          ovf_q;

  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  // Unsigned magnitude; -2^(W-1) maps to 2^(W-1), which still fits in W bits.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = $unsigned(v);
    return v[W-1] ? (~u + {{(W-1){1'b0}}, 1'b1}) : u;
  endfunction

  // P = {h, l} is the product magnitude. A negative result may reach
  // exactly 2^(W-1); a positive one must stay below it.
  function automatic logic overflow_flag(input logic sgn,
                                         input logic [W-1:0] h,
                                         input logic [W-1:0] l);
    if (h != '0)
      return 1'b1;
    if (!sgn)
      return l[W-1];
    return l[W-1] && (l[W-2:0] != '0);
  endfunction

  full_adder #(.DATA_WIDTH(W)) u_adder (
    .a         (add_a),
    .b         (add_b),
    .carry_in  (add_cin),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // Adder input mux: accumulate in CALC, two's-complement negate in NEG.
  always_comb begin
    add_a   = hi;
    add_b   = lo[0] ? mcand : '0;
    add_cin = 1'b0;
    if (state_q == NEG) begin
      add_a   = sign ? ~lo : lo;
      add_b   = '0;
      add_cin = sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          state_d = CALC;
      end
      CALC: begin
        if (count == CW'(W - 1))
          state_d = NEG;
      end
      NEG: begin
        state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      sign     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mcand <= magnitude(bus.a);
            lo    <= magnitude(bus.b);
            sign  <= bus.a[W-1] ^ bus.b[W-1];
            hi    <= '0;
            count <= '0;
          end
        end
        CALC: begin
          // {hi, lo} <= {carry_out, sum, lo} >> 1
          hi    <= {add_cout, add_sum[W-1:1]};
          lo    <= {add_sum[0], lo[W-1:1]};
          count <= count + 1'b1;
        end
        NEG: begin
          result_q <= add_sum;
          ovf_q    <= overflow_flag(sign, hi, lo);
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential signed two's-complement multiplier for the calculator datapath, sitting directly downstream of the ripple `full_adder`. It consumes the adder's `sum`/`carry_out` once per clock. It accepts two `DATA_WIDTH`-bit operands over a valid/ready handshake and runs a right-shift shift-and-add loop. It returns a `DATA_WIDTH`-bit signed product with an overflow flag.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-high.
- `DATA_WIDTH`, default 16: operand and result width; must be ≥ 2.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operands `a`, `b` are valid.
- `in_ready`, output, 1: the block can accept operands.
- `a`, input, DATA_WIDTH: multiplicand, signed.
- `b`, input, DATA_WIDTH: multiplier, signed.
- `out_valid`, output, 1: `result`/`overflow` are valid.
- `out_ready`, input, 1: the consumer takes the result.
- `result`, output, DATA_WIDTH: low `DATA_WIDTH` bits of the signed product.
- `overflow`, output, 1: the true product does not fit in `DATA_WIDTH` signed bits.

## Operation
- States: IDLE, CALC, NEG, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `mcand` = |a| and register `lo` = |b|. Magnitudes are unsigned, DATA_WIDTH bits, so |−2^(W−1)| = 2^(W−1) fits.
  - Latch `sign` = a[W−1]^b[W−1]; clear `hi` (W bits); set `count`=0; go to CALC.
- CALC, one step per cycle:
  - Adder inputs: a=`hi`, b=(`lo[0]` ? `mcand` : 0), carry_in=0.
  - Update {`hi`,`lo`} ← {carry_out, sum, `lo`} >> 1, keeping the low 2W bits.
  - `count`++. After step W (count reaches W), go to NEG.
- NEG, one cycle, reusing the same adder:
  - Adder inputs: a = `sign` ? ~`lo` : `lo`, b=0, carry_in=`sign`.
  - `result` ← sum.
  - Overflow rule, where P = {`hi`,`lo`}:
    - `sign`=0: `overflow` ← (P ≥ 2^(W−1)), i.e. `hi`≠0 or `lo[W−1]`.
    - `sign`=1: `overflow` ← (P > 2^(W−1)).
  - Go to DONE.
- DONE:
  - `out_valid`=1. `result`/`overflow` hold stable until `out_valid && out_ready`, then go to IDLE.
  - On overflow, `result` is the two's-complement wrap (low W bits of the exact signed product).
- `in_ready` is high only in IDLE. Input accept and output handshake never coincide.
- A zero operand still takes the full loop; there is no early exit.
- Reset at any point, including mid-CALC: immediately return to IDLE; partial work is discarded.
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `overflow`=0; internal `hi`, `lo`, `mcand`, `count`, `sign` = 0.

## Timing
- Accept at edge T: CALC steps on edges T+1…T+W, NEG on edge T+W+1.
- `out_valid` rises after edge T+W+1, so latency is W+1 cycles (17 for W=16).
- Earliest next accept: the edge after the output handshake. Throughput is one operation per W+3 cycles under continuous ready.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- The adder is a single combinational path: W-bit ripple plus the mux, within one cycle.

## Structure
- Shared package `calc_pkg`:
  - `mult_state_t` enum {IDLE, CALC, NEG, DONE}.
  - A `count` width function/constant equal to $clog2(DATA_WIDTH+1).
- Sub-module: exactly one `full_adder #(.DATA_WIDTH(DATA_WIDTH))` instance, input-muxed between CALC and NEG. No second adder and no `*` operator.

## Test plan
- a=3, b=5, out_ready=1 → `out_valid` exactly 17 cycles after accept; `result`=15, `overflow`=0.
- a=−7 (0xFFF9), b=6 → `result`=0xFFD6 (−42), `overflow`=0.
- a=0x8000, b=1 → `result`=0x8000, `overflow`=0. Then a=0x8000, b=0xFFFF (−1) → `result`=0x8000, `overflow`=1.
- a=256, b=256 → `result`=0x0000, `overflow`=1. Also a=0, b=0x7FFF → `result`=0 after the full 17 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `result`, `overflow` stable and `in_ready`=0 throughout, with `in_valid` asserted; release → IDLE next cycle.
- Assert `rst` asynchronously at CALC step 8 → `out_valid`=0 and `in_ready`=1 immediately. A new request 3×5 after release yields 15 with no residue.
